controlador_display_oled: RTL and testbench

// - Streams a 128x64 monochrome frame to an SSD1306-class OLED over a 4-wire, write-only SPI link.
// - After reset it pulses the panel reset line, then sends a fixed init command list.
// - It then refreshes forever: 1024 data bytes per frame, one byte per page/column pair, taken from data_to_send.
// - Sits between the frame-buffer/game logic and the FPGA pins driving the OLED PMOD.

---
 rtl/display_pkg.sv | 64 ++++++
 rtl/spi_byte_tx.sv | 65 ++++++
 rtl/controlador_display_oled.sv | 137 +++++++++++++
 tb/tb_controlador_display_oled.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the OLED controller: FSM state encoding, sizes and
// the SSD1306 power-up command list.
// Build option: CONTROLADOR_DISPLAY_FLIP_EN selects segment remap / COM scan
// direction bytes that rotate the image by 180 degrees.
package display_pkg;

    typedef enum logic [2:0] {
        S_RST_LOW   = 3'd0,
        S_RST_WAIT  = 3'd1,
        S_LOAD      = 3'd2,
        S_SHIFT     = 3'd3,
        S_DATA_DONE = 3'd4,
        S_CMD_DONE  = 3'd5
    } state_t;

    localparam int INIT_LEN    = 31;
    localparam int FRAME_BYTES = 1024;

    // Power-up command list; vertical addressing over the full 128x64 window.
    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:  b = 8'hAE;
            5'd1:  b = 8'hD5;
            5'd2:  b = 8'h80;
            5'd3:  b = 8'hA8;
            5'd4:  b = 8'h3F;
            5'd5:  b = 8'hD3;
            5'd6:  b = 8'h00;
            5'd7:  b = 8'h40;
            5'd8:  b = 8'h8D;
            5'd9:  b = 8'h14;
            5'd10: b = 8'h20;
            5'd11: b = 8'h01;
            5'd12: b = 8'h21;
            5'd13: b = 8'h00;
            5'd14: b = 8'h7F;
            5'd15: b = 8'h22;
            5'd16: b = 8'h00;
            5'd17: b = 8'h07;
`ifdef CONTROLADOR_DISPLAY_FLIP_EN
            5'd18: b = 8'hA1;
            5'd19: b = 8'hC8;
`else
            5'd18: b = 8'hA0;
            5'd19: b = 8'hC0;
`endif
            5'd20: b = 8'hDA;
            5'd21: b = 8'h12;
            5'd22: b = 8'h81;
            5'd23: b = 8'hCF;
            5'd24: b = 8'hD9;
            5'd25: b = 8'hF1;
            5'd26: b = 8'hDB;
            5'd27: b = 8'h40;
            5'd28: b = 8'hA4;
            5'd29: b = 8'hA6;
            5'd30: b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Write-only SPI mode-0 byte shifter with its own sclk divider.
// A start pulse loads the byte; done is high for the final cycle of the
// last sclk high half so the caller can leave SHIFT on the same edge that
// drops sclk.
module spi_byte_tx
    import display_pkg::*;
#(
    parameter logic [10:0] CLK_DIV = 11'd50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       sclk,
    output logic       sdin,
    output logic       done
);

    // A divider of 0 is treated as 1 so the half period never collapses.
    localparam logic [10:0] HALF_TC = (CLK_DIV == 11'd0) ? 11'd0 : CLK_DIV - 11'd1;

    logic [10:0] div_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        busy;

    assign done = busy && sclk && (div_cnt == 11'd0) && (bit_cnt == 3'd0);

    // Half-period down-counter drives sclk; sdin changes only on the falling side.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk    <= 1'b0;
            sdin    <= 1'b0;
            busy    <= 1'b0;
            div_cnt <= 11'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
        end else if (start) begin
            busy    <= 1'b1;
            sclk    <= 1'b0;
            sdin    <= byte_in[7];
            shreg   <= {byte_in[6:0], 1'b0};
            div_cnt <= HALF_TC;
            bit_cnt <= 3'd7;
        end else if (busy) begin
            if (div_cnt != 11'd0) begin
                div_cnt <= div_cnt - 11'd1;
            end else if (!sclk) begin
                sclk    <= 1'b1;
                div_cnt <= HALF_TC;
            end else begin
                sclk    <= 1'b0;
                div_cnt <= HALF_TC;
                if (bit_cnt == 3'd0) begin
                    busy <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt - 3'd1;
                    sdin    <= shreg[7];
                    shreg   <= {shreg[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/controlador_display_oled.sv
// SSD1306 128x64 OLED streamer: panel reset pulse, init command list, then
// endless refresh of 1024 pixel bytes (vertical addressing) from data_to_send.
// Build option: CONTROLADOR_DISPLAY_FLIP_EN (rotated init bytes, see display_pkg).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_RST_LOW   | io_reset held low for RST_LOW cycles
// S_RST_WAIT  | io_reset high, wait RST_LOW cycles before first command
// S_LOAD      | latch next byte (ROM or data_to_send), drop io_cs
// S_SHIFT     | spi_byte_tx clocks 8 bits out, MSB first
// S_DATA_DONE | one cycle, advance pixel byte index
// S_CMD_DONE  | one cycle, advance command index, enter data phase after last
// 6, 7        | unreachable, recover to S_RST_LOW
module controlador_display_oled
    import display_pkg::*;
#(
    parameter logic [10:0] CLK_DIV = 11'd50,
    parameter logic [15:0] RST_LOW = 16'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_to_send,
    output logic       io_sclk,
    output logic       io_sdin,
    output logic       io_cs,
    output logic       io_dc,
    output logic       io_reset
);

    localparam logic [15:0] RST_TC   = (RST_LOW == 16'd0) ? 16'd0 : RST_LOW - 16'd1;
    localparam int          BYTE_W   = $clog2(FRAME_BYTES);
    localparam logic [4:0]  LAST_CMD = 5'(INIT_LEN - 1);

    state_t              state;
    state_t              next_state;
    logic [7:0]          dataToSend;
    logic [15:0]         rst_tmr;
    logic [4:0]          cmd_idx;
    logic [BYTE_W-1:0]   byte_idx;
    logic                data_phase;
    logic [7:0]          load_byte;
    logic                tx_start;
    logic                tx_done;

    assign load_byte = data_phase ? data_to_send : init_rom(cmd_idx);
    assign tx_start  = (state == S_LOAD);

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .byte_in (load_byte),
        .sclk    (io_sclk),
        .sdin    (io_sdin),
        .done    (tx_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RST_LOW;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            S_RST_LOW:   if (rst_tmr == 16'd0) next_state = S_RST_WAIT;
            S_RST_WAIT:  if (rst_tmr == 16'd0) next_state = S_LOAD;
            S_LOAD:      next_state = S_SHIFT;
            S_SHIFT:     if (tx_done) next_state = data_phase ? S_DATA_DONE : S_CMD_DONE;
            S_DATA_DONE: next_state = S_LOAD;
            S_CMD_DONE:  next_state = S_LOAD;
            default:     next_state = S_RST_LOW;
        endcase
    end

    // Panel pins, reset timer and byte/command counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_reset   <= 1'b0;
            io_cs      <= 1'b1;
            io_dc      <= 1'b0;
            dataToSend <= 8'h00;
            rst_tmr    <= RST_TC;
            cmd_idx    <= 5'd0;
            byte_idx   <= '0;
            data_phase <= 1'b0;
        end else begin
            case (state)
                S_RST_LOW: begin
                    if (rst_tmr == 16'd0) begin
                        io_reset <= 1'b1;
                        rst_tmr  <= RST_TC;
                    end else begin
                        rst_tmr <= rst_tmr - 16'd1;
                    end
                end
                S_RST_WAIT: begin
                    if (rst_tmr != 16'd0) rst_tmr <= rst_tmr - 16'd1;
                end
                S_LOAD: begin
                    dataToSend <= load_byte;
                    io_dc      <= data_phase;
                    io_cs      <= 1'b0;
                end
                S_SHIFT: begin
                    if (tx_done) io_cs <= 1'b1;
                end
                S_DATA_DONE: begin
                    byte_idx <= byte_idx + 1'b1;
                end
                S_CMD_DONE: begin
                    cmd_idx <= cmd_idx + 5'd1;
                    if (cmd_idx == LAST_CMD) begin
                        data_phase <= 1'b1;
                        byte_idx   <= '0;
                    end
                end
                default: begin
                    io_reset   <= 1'b0;
                    io_cs      <= 1'b1;
                    io_dc      <= 1'b0;
                    rst_tmr    <= RST_TC;
                    cmd_idx    <= 5'd0;
                    data_phase <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_display_oled.sv
// Bench for controlador_display_oled: decodes the SPI pins into byte records
// and checks them against the expected init list and a LOAD-time data model.
`timescale 1ns/1ps
module tb_controlador_display_oled;

    localparam logic [10:0] CLK_DIV  = 11'd2;
    localparam logic [15:0] RST_LOW  = 16'd4;
    localparam int          BYTE_CYC = 16 * 2 + 2;
    localparam int          NFRAME   = 1024;

`ifdef CONTROLADOR_DISPLAY_FLIP_EN
    localparam logic [7:0] ROM_EXP [31] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h01, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hA1, 8'hC8,
        8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    localparam logic [7:0] EXP_B19 = 8'hA1;
    localparam logic [7:0] EXP_B20 = 8'hC8;
`else
    localparam logic [7:0] ROM_EXP [31] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h01, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hA0, 8'hC0,
        8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    localparam logic [7:0] EXP_B19 = 8'hA0;
    localparam logic [7:0] EXP_B20 = 8'hC0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_to_send = 8'h00;
    logic       io_sclk, io_sdin, io_cs, io_dc, io_reset;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] b;
        logic       dc;
        int         nbits;
    } rec_t;

    rec_t       rec_q[$];
    rec_t       mon_rec;
    logic [7:0] mon_sh   = 8'h00;
    logic       mon_dc   = 1'b0;
    int         mon_bits = 0;
    int         cyc      = 0;
    int         dd_count = 0;
    int         cd_count = 0;
    int         init_base = 0;

    controlador_display_oled #(
        .CLK_DIV (CLK_DIV),
        .RST_LOW (RST_LOW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_to_send (data_to_send),
        .io_sclk      (io_sclk),
        .io_sdin      (io_sdin),
        .io_cs        (io_cs),
        .io_dc        (io_dc),
        .io_reset     (io_reset)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Panel-side view: sample on sclk rise, close a record when cs goes high.
    always @(posedge io_sclk or posedge io_cs) begin
        if (io_cs) begin
            mon_rec.b     = mon_sh;
            mon_rec.dc    = mon_dc;
            mon_rec.nbits = mon_bits;
            rec_q.push_back(mon_rec);
            mon_bits = 0;
        end else begin
            mon_sh = {mon_sh[6:0], io_sdin};
            mon_dc = io_dc;
            mon_bits++;
        end
    end

    // Count completion pulses of data and command bytes.
    always @(negedge clk) begin
        if (dut.state == 3'd4) dd_count++;
        if (dut.state == 3'd5) cd_count++;
    end

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut.state == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_recs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rec_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lo;
        int hi;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (io_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", io_sclk); end
        n_checks++; if (io_sdin !== 1'b0) begin n_fail++; $display("FAIL reset_sdin: got %b want 0", io_sdin); end
        n_checks++; if (io_cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", io_cs); end
        n_checks++; if (io_dc !== 1'b0) begin n_fail++; $display("FAIL reset_dc: got %b want 0", io_dc); end
        n_checks++; if (io_reset !== 1'b0) begin n_fail++; $display("FAIL reset_io_reset: got %b want 0", io_reset); end
        n_checks++; if (dut.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dut.state); end
        n_checks++; if (dut.dataToSend !== 8'h00) begin n_fail++; $display("FAIL reset_dataToSend: got %h want 00", dut.dataToSend); end
        @(posedge clk);
        #1 rst = 1'b0;
        init_base = rec_q.size();
        lo = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (io_reset !== 1'b0) break;
            lo++;
        end
        n_checks++; if (lo != int'(RST_LOW)) begin n_fail++; $display("FAIL rst_low_len: got %0d cycles want %0d", lo, RST_LOW); end
        hi = 0;
        while (dut.state == 3'd1 && io_reset === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        n_checks++; if (hi != int'(RST_LOW)) begin n_fail++; $display("FAIL rst_wait_len: got %0d cycles want %0d", hi, RST_LOW); end
        n_checks++; if (dut.state !== 3'd2) begin n_fail++; $display("FAIL after_wait_state: got %0d want 2", dut.state); end
    endtask

    task automatic test_init();
        bit   ok;
        rec_t r;
        wait_recs(init_base + 32, 40 * BYTE_CYC, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL init_timeout: got %0d records want %0d", rec_q.size() - init_base, 32); end
        if (rec_q.size() >= init_base + 32) begin
            for (int i = 0; i < 31; i++) begin
                r = rec_q[init_base + i];
                n_checks++; if (r.b !== ROM_EXP[i]) begin n_fail++; $display("FAIL init_byte[%0d]: got %h want %h", i, r.b, ROM_EXP[i]); end
                n_checks++; if (r.dc !== 1'b0) begin n_fail++; $display("FAIL init_dc[%0d]: got %b want 0", i, r.dc); end
                n_checks++; if (r.nbits != 8) begin n_fail++; $display("FAIL init_bits[%0d]: got %0d want 8", i, r.nbits); end
            end
            r = rec_q[init_base + 31];
            n_checks++; if (r.dc !== 1'b1) begin n_fail++; $display("FAIL first_data_dc: got %b want 1", r.dc); end
        end
        n_checks++; if (cd_count != 31) begin n_fail++; $display("FAIL cmd_count: got %0d want 31", cd_count); end
    endtask

    task automatic test_flip();
        if (rec_q.size() >= init_base + 20) begin
            n_checks++; if (rec_q[init_base + 18].b !== EXP_B19) begin n_fail++; $display("FAIL flip_cmd19: got %h want %h", rec_q[init_base + 18].b, EXP_B19); end
            n_checks++; if (rec_q[init_base + 19].b !== EXP_B20) begin n_fail++; $display("FAIL flip_cmd20: got %h want %h", rec_q[init_base + 19].b, EXP_B20); end
        end else begin
            n_checks++; n_fail++; $display("FAIL flip_missing: got %0d records want 20", rec_q.size() - init_base);
        end
    endtask

    task automatic test_data_pattern();
        bit ok;
        int idx;
        int last;
        @(negedge clk);
        data_to_send = 8'hA5;
        wait_state(3'd4, 2 * BYTE_CYC + 10, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pattern_align: got timeout want DATA_DONE"); end
        idx  = rec_q.size();
        last = cyc;
        for (int j = 0; j < 3; j++) begin
            wait_state(3'd4, BYTE_CYC + 5, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL pattern_done[%0d]: got timeout want DATA_DONE", j); end
            n_checks++; if (dut.dataToSend !== 8'hA5) begin n_fail++; $display("FAIL pattern_hold[%0d]: got %h want a5", j, dut.dataToSend); end
            n_checks++; if (cyc - last != BYTE_CYC) begin n_fail++; $display("FAIL pattern_period[%0d]: got %0d want %0d", j, cyc - last, BYTE_CYC); end
            last = cyc;
        end
        n_checks++;
        if (rec_q.size() < idx + 3) begin
            n_fail++; $display("FAIL pattern_records: got %0d want 3", rec_q.size() - idx);
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_checks++; if (rec_q[idx + j].b !== 8'hA5) begin n_fail++; $display("FAIL pattern_bits[%0d]: got %h want a5", j, rec_q[idx + j].b); end
                n_checks++; if (rec_q[idx + j].dc !== 1'b1) begin n_fail++; $display("FAIL pattern_dc[%0d]: got %b want 1", j, rec_q[idx + j].dc); end
                n_checks++; if (rec_q[idx + j].nbits != 8) begin n_fail++; $display("FAIL pattern_edges[%0d]: got %0d want 8", j, rec_q[idx + j].nbits); end
            end
        end
    endtask

    // Random data changes at any non-LOAD time; model keeps the value seen in LOAD.
    task automatic test_random_frame();
        bit         ok;
        int         base;
        int         guard;
        int         col;
        int         page;
        int         seen_dd;
        int         ncmp;
        logic [7:0] exp_q[$];
        wait_state(3'd2, BYTE_CYC + 5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_align: got timeout want LOAD"); end
        base    = rec_q.size();
        guard   = 0;
        col     = (dd_count / 8) % 128;
        page    = dd_count % 8;
        seen_dd = dd_count;
        while (dd_count < NFRAME + 1 && guard < (NFRAME + 4) * BYTE_CYC) begin
            if (dut.state == 3'd2) begin
                exp_q.push_back(data_to_send);
            end else if ($urandom_range(0, 3) == 0) begin
                data_to_send = 8'($urandom);
            end
            if (dd_count != seen_dd) begin
                seen_dd = dd_count;
                page++;
                if (page == 8) begin
                    page = 0;
                    col++;
                    if (col == 128) begin
                        col = 0;
                        $display("note: frame wrapped after %0d data bytes", dd_count);
                    end
                end
            end
            @(negedge clk);
            guard++;
        end
        n_checks++; if (dd_count < NFRAME + 1) begin n_fail++; $display("FAIL frame_timeout: got %0d data bytes want %0d", dd_count, NFRAME + 1); end
        ncmp = rec_q.size() - base;
        if (ncmp > exp_q.size()) ncmp = exp_q.size();
        n_checks++; if (ncmp < NFRAME - 40) begin n_fail++; $display("FAIL frame_count: got %0d bytes want >= %0d", ncmp, NFRAME - 40); end
        for (int i = 0; i < ncmp; i++) begin
            n_checks++; if (rec_q[base + i].b !== exp_q[i]) begin n_fail++; $display("FAIL frame_byte[%0d]: got %h want %h", i, rec_q[base + i].b, exp_q[i]); end
            n_checks++; if (rec_q[base + i].dc !== 1'b1) begin n_fail++; $display("FAIL frame_dc[%0d]: got %b want 1", i, rec_q[base + i].dc); end
        end
        n_checks++; if (cd_count != 31) begin n_fail++; $display("FAIL frame_no_resend: got %0d commands want 31", cd_count); end
        n_checks++;
        if (rec_q.size() <= init_base + 31 + NFRAME) begin
            n_fail++; $display("FAIL wrap_byte_missing: got %0d records want %0d", rec_q.size() - init_base, 32 + NFRAME);
        end else begin
            n_checks++; if (rec_q[init_base + 31 + NFRAME].dc !== 1'b1) begin n_fail++; $display("FAIL wrap_dc: got %b want 1", rec_q[init_base + 31 + NFRAME].dc); end
            n_checks++; if (rec_q[init_base + 31 + NFRAME].nbits != 8) begin n_fail++; $display("FAIL wrap_bits: got %0d want 8", rec_q[init_base + 31 + NFRAME].nbits); end
        end
    endtask

    task automatic test_mid_byte_reset();
        bit ok;
        bit found;
        int base;
        wait_state(3'd3, BYTE_CYC + 5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_align: got timeout want SHIFT"); end
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (mon_bits == 4 && io_sclk === 1'b0 && dut.state == 3'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL midrst_bit3: got none want bit 3 low phase"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (io_cs !== 1'b1) begin n_fail++; $display("FAIL midrst_cs: got %b want 1", io_cs); end
        n_checks++; if (io_sclk !== 1'b0) begin n_fail++; $display("FAIL midrst_sclk: got %b want 0", io_sclk); end
        n_checks++; if (dut.state !== 3'd0) begin n_fail++; $display("FAIL midrst_state: got %0d want 0", dut.state); end
        n_checks++; if (io_reset !== 1'b0) begin n_fail++; $display("FAIL midrst_io_reset: got %b want 0", io_reset); end
        rst  = 1'b0;
        base = rec_q.size();
        n_checks++; if (base == 0 || rec_q[base - 1].nbits != 4) begin n_fail++; $display("FAIL midrst_partial: got %0d bits want 4", (base == 0) ? -1 : rec_q[base - 1].nbits); end
        wait_recs(base + 1, 4 * int'(RST_LOW) + 2 * BYTE_CYC, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midrst_replay_timeout: got no byte want ae"); end
        if (ok) begin
            n_checks++; if (rec_q[base].b !== 8'hAE) begin n_fail++; $display("FAIL midrst_replay_byte: got %h want ae", rec_q[base].b); end
            n_checks++; if (rec_q[base].dc !== 1'b0) begin n_fail++; $display("FAIL midrst_replay_dc: got %b want 0", rec_q[base].dc); end
            n_checks++; if (rec_q[base].nbits != 8) begin n_fail++; $display("FAIL midrst_replay_bits: got %0d want 8", rec_q[base].nbits); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_flip();
        test_data_pattern();
        test_random_frame();
        test_mid_byte_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
